// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_ctrl
// Purpose : MEM-stage dcache access FSM with LL/SC link register and halt latch.
// Revision: 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_read_o,
    input  logic              mem_write_o,
    input  logic              datomic_o,
    input  logic              halt_o,
    input  logic [WORD_W-1:0] alu_out_o,
    input  logic [WORD_W-1:0] rdat2_o,
    input  logic              advance,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              link_valid,
    output logic              halt_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              op_read;
    logic              op_write;
    logic              op_atomic;
    logic [WORD_W-3:0] link_word;

    logic              memop;
    logic              is_sc;
    logic              link_ok;
    logic              issue;
    logic              sc_fail;
    logic              complete;
    logic              ll_done;
    logic              st_clear;
    logic              snoop_link;
    logic              snoop_new;

    logic              unused_snoop_bits;
    assign unused_snoop_bits = &{1'b0, snoop_addr[1:0]};

    assign memop      = mem_read_o | mem_write_o;
    assign is_sc      = datomic_o & mem_write_o;
    assign link_ok    = link_valid & (link_word == alu_out_o[WORD_W-1:2]);
    assign issue      = (state == IDLE) & memop;
    assign sc_fail    = is_sc & ~link_ok;
    assign complete   = (state == REQ) & dhit;
    assign ll_done    = complete & op_read & op_atomic;
    assign st_clear   = complete & op_write & ~op_atomic &
                        (dmemaddr[WORD_W-1:2] == link_word);
    assign snoop_link = snoop_inv & (snoop_addr[WORD_W-1:2] == link_word);
    assign snoop_new  = snoop_inv & (snoop_addr[WORD_W-1:2] == dmemaddr[WORD_W-1:2]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request strobes come from registered state only, so reset kills them at once.
    always_comb begin
        state_next = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = memop;
                if (memop) begin
                    state_next = sc_fail ? DONE : REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                dmemREN   = op_read;
                dmemWEN   = op_write;
                if (dhit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (advance) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_read    <= 1'b0;
            op_write   <= 1'b0;
            op_atomic  <= 1'b0;
            dmemaddr   <= '0;
            dmemstore  <= '0;
            mem_rdata  <= '0;
            link_word  <= '0;
            link_valid <= 1'b0;
            halt_flag  <= 1'b0;
        end else begin
            if (issue) begin
                op_read   <= mem_read_o;
                op_write  <= mem_write_o;
                op_atomic <= datomic_o;
                if (sc_fail) begin
                    mem_rdata <= '0;
                end else begin
                    dmemaddr  <= alu_out_o;
                    dmemstore <= rdat2_o;
                end
            end

            if (complete) begin
                if (op_read) begin
                    mem_rdata <= dmemload;
                end else if (op_write & op_atomic) begin
                    mem_rdata <= {{(WORD_W-1){1'b0}}, 1'b1};
                end
            end

            // A same-word invalidate on the LL completion edge must win over the new link.
            if (ll_done) begin
                link_word  <= dmemaddr[WORD_W-1:2];
                link_valid <= ~snoop_new;
            end else if ((issue & is_sc) | st_clear | snoop_link) begin
                link_valid <= 1'b0;
            end

            if ((state == IDLE) & ~memop & halt_o) begin
                halt_flag <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_ctrl
// Purpose : Vector table, randomized model-checked ops and reset/halt sequences.
// Revision: 1.0
// ============================================================================
module tb_mem_access_ctrl;

    localparam int WORD_W = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              mem_read_o, mem_write_o, datomic_o, halt_o;
    logic [WORD_W-1:0] alu_out_o, rdat2_o;
    logic              advance, dhit;
    logic [WORD_W-1:0] dmemload;
    logic              snoop_inv;
    logic [WORD_W-1:0] snoop_addr;
    logic              dmemREN, dmemWEN;
    logic [WORD_W-1:0] dmemaddr, dmemstore;
    logic              mem_stall;
    logic [WORD_W-1:0] mem_rdata;
    logic              link_valid, halt_flag;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.WORD_W(WORD_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .datomic_o  (datomic_o),
        .halt_o     (halt_o),
        .alu_out_o  (alu_out_o),
        .rdat2_o    (rdat2_o),
        .advance    (advance),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .mem_stall  (mem_stall),
        .mem_rdata  (mem_rdata),
        .link_valid (link_valid),
        .halt_flag  (halt_flag)
    );

    typedef enum int {K_LOAD, K_STORE, K_LL, K_SC, K_SNOOP} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ld;
        int          hit_at;
        int          hold;
        bit          snoop;
        logic [31:0] saddr;
        int          exp_stall;
        int          exp_ren;
        int          exp_wen;
        logic [31:0] exp_rdata;
        bit          exp_link;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural link reservation and last result only.
    bit          m_link_v;
    logic [31:0] m_link_addr;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(kind_t k, logic [31:0] a, logic [31:0] d, logic [31:0] ld,
                                int hit, int hold, bit sn, logic [31:0] sa, int es, int er,
                                int ew, logic [31:0] erd, bit el);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.ld = ld; v.hit_at = hit; v.hold = hold;
        v.snoop = sn; v.saddr = sa; v.exp_stall = es; v.exp_ren = er; v.exp_wen = ew;
        v.exp_rdata = erd; v.exp_link = el;
        return v;
    endfunction

    function automatic bit same_word(logic [31:0] a, logic [31:0] b);
        return (a / 4) == (b / 4);
    endfunction

    task automatic model(inout vec_t v);
        bit issued = 1'b1;
        case (v.kind)
            K_LOAD:  m_rdata = v.ld;
            K_LL: begin
                m_rdata = v.ld; m_link_addr = v.addr; m_link_v = 1'b1;
            end
            K_STORE: if (m_link_v && same_word(v.addr, m_link_addr)) m_link_v = 1'b0;
            K_SC: begin
                issued   = m_link_v && same_word(v.addr, m_link_addr);
                m_link_v = 1'b0;
                m_rdata  = issued ? 32'd1 : 32'd0;
            end
            default: begin
                issued = 1'b0;
                if (same_word(v.saddr, m_link_addr)) m_link_v = 1'b0;
            end
        endcase
        if (issued && v.snoop && same_word(v.saddr, m_link_addr)) m_link_v = 1'b0;
        v.exp_stall = issued ? 1 + v.hit_at : 1;
        v.exp_ren   = (issued && (v.kind == K_LOAD || v.kind == K_LL)) ? v.hit_at : 0;
        v.exp_wen   = (issued && (v.kind == K_STORE || v.kind == K_SC)) ? v.hit_at : 0;
        v.exp_rdata = m_rdata;
        v.exp_link  = m_link_v;
    endtask

    // Drives one EX/MEM instruction from a negedge until the DUT leaves DONE.
    task automatic apply(input vec_t v, input string tag);
        int          n_stall = 0, n_ren = 0, n_wen = 0, n_bursts = 0, n_done = 0;
        bit          prev_req = 1'b0, finished = 1'b0, addr_ok = 1'b1, hold_ok = 1'b1;
        logic [31:0] rd = '0;
        if (v.kind == K_SNOOP) begin
            snoop_inv = 1'b1; snoop_addr = v.saddr;
            #1 check({tag, " snoop stall"}, {31'd0, mem_stall}, 32'd0);
            @(negedge CLK);
            snoop_inv = 1'b0;
            check({tag, " snoop link"}, {31'd0, link_valid}, {31'd0, v.exp_link});
            return;
        end
        mem_read_o  = (v.kind == K_LOAD) || (v.kind == K_LL);
        mem_write_o = (v.kind == K_STORE) || (v.kind == K_SC);
        datomic_o   = (v.kind == K_LL) || (v.kind == K_SC);
        alu_out_o   = v.addr;
        rdat2_o     = v.data;
        advance     = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            #1;
            if (mem_stall) n_stall++;
            if (dmemREN) n_ren++;
            if (dmemWEN) n_wen++;
            if ((dmemREN || dmemWEN) && !prev_req) n_bursts++;
            prev_req = dmemREN || dmemWEN;
            if (dmemREN || dmemWEN) begin
                if (dmemaddr !== v.addr || dmemstore !== v.data) addr_ok = 1'b0;
                dhit       = ((n_ren + n_wen) == v.hit_at);
                dmemload   = dhit ? v.ld : $urandom;
                snoop_inv  = dhit && v.snoop;
                snoop_addr = v.saddr;
            end else begin
                dhit = 1'b0; snoop_inv = 1'b0;
                if (!mem_stall) begin
                    n_done++;
                    if (n_done == 1) rd = mem_rdata;
                    else if (mem_rdata !== rd) hold_ok = 1'b0;
                    advance = (n_done > v.hold);
                    if (advance) finished = 1'b1;
                end
            end
            @(negedge CLK);
        end
        mem_read_o = 1'b0; mem_write_o = 1'b0; datomic_o = 1'b0;
        advance = 1'b0; dhit = 1'b0; snoop_inv = 1'b0;
        check({tag, " completed"}, {31'd0, finished}, 32'd1);
        check({tag, " stall cycles"}, n_stall, v.exp_stall);
        check({tag, " ren cycles"}, n_ren, v.exp_ren);
        check({tag, " wen cycles"}, n_wen, v.exp_wen);
        check({tag, " bursts"}, n_bursts, (v.exp_ren + v.exp_wen) > 0 ? 1 : 0);
        check({tag, " done cycles"}, n_done, v.hold + 1);
        check({tag, " addr/data stable"}, {31'd0, addr_ok}, 32'd1);
        check({tag, " rdata hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, " rdata"}, rd, v.exp_rdata);
        check({tag, " link"}, {31'd0, link_valid}, {31'd0, v.exp_link});
    endtask

    vec_t tbl[14];
    vec_t rv;
    logic [31:0] pool[5];

    initial begin
        RST = 1'b1;
        mem_read_o = 0; mem_write_o = 0; datomic_o = 0; halt_o = 0;
        alu_out_o = '0; rdat2_o = '0; advance = 0; dhit = 0; dmemload = '0;
        snoop_inv = 0; snoop_addr = '0;

        tbl[0]  = mk(K_LOAD,  32'h100, 32'h0,      32'hDEADBEEF, 2, 0, 0, 32'h0,   3, 2, 0, 32'hDEADBEEF, 0);
        tbl[1]  = mk(K_STORE, 32'h204, 32'h12345678, 32'h0,      1, 3, 0, 32'h0,   2, 0, 1, 32'hDEADBEEF, 0);
        tbl[2]  = mk(K_LL,    32'h300, 32'h0,      32'hAAAA0000, 1, 0, 0, 32'h0,   2, 1, 0, 32'hAAAA0000, 1);
        tbl[3]  = mk(K_SC,    32'h300, 32'h5,      32'h0,        1, 0, 0, 32'h0,   2, 0, 1, 32'h1,        0);
        tbl[4]  = mk(K_LL,    32'h300, 32'h0,      32'h11,       1, 0, 0, 32'h0,   2, 1, 0, 32'h11,       1);
        tbl[5]  = mk(K_SNOOP, 32'h0,   32'h0,      32'h0,        0, 0, 1, 32'h300, 0, 0, 0, 32'h0,        0);
        tbl[6]  = mk(K_SC,    32'h300, 32'h7,      32'h0,        1, 0, 0, 32'h0,   1, 0, 0, 32'h0,        0);
        tbl[7]  = mk(K_LL,    32'h300, 32'h0,      32'h22,       2, 0, 1, 32'h300, 3, 2, 0, 32'h22,       0);
        tbl[8]  = mk(K_LL,    32'h304, 32'h0,      32'h33,       1, 0, 0, 32'h0,   2, 1, 0, 32'h33,       1);
        tbl[9]  = mk(K_STORE, 32'h306, 32'h9,      32'h0,        1, 0, 0, 32'h0,   2, 0, 1, 32'h33,       0);
        tbl[10] = mk(K_LL,    32'h304, 32'h0,      32'h44,       1, 1, 0, 32'h0,   2, 1, 0, 32'h44,       1);
        tbl[11] = mk(K_SC,    32'h308, 32'h1,      32'h0,        1, 0, 0, 32'h0,   1, 0, 0, 32'h0,        0);
        tbl[12] = mk(K_LL,    32'h300, 32'h0,      32'h55,       1, 0, 0, 32'h0,   2, 1, 0, 32'h55,       1);
        tbl[13] = mk(K_SC,    32'h302, 32'h6,      32'h0,        2, 0, 1, 32'h300, 3, 0, 2, 32'h1,        0);

        repeat (2) @(negedge CLK);
        check("reset ren",   {31'd0, dmemREN},    32'd0);
        check("reset wen",   {31'd0, dmemWEN},    32'd0);
        check("reset stall", {31'd0, mem_stall},  32'd0);
        check("reset addr",  dmemaddr,            32'd0);
        check("reset rdata", mem_rdata,           32'd0);
        check("reset link",  {31'd0, link_valid}, 32'd0);
        check("reset halt",  {31'd0, halt_flag},  32'd0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Model state left behind by the table: no reservation, last result 1.
        m_link_v = 1'b0; m_link_addr = 32'h300; m_rdata = 32'd1;
        pool[0] = 32'h300; pool[1] = 32'h302; pool[2] = 32'h304; pool[3] = 32'h400; pool[4] = 32'h308;
        for (int i = 0; i < 200; i++) begin
            rv.kind   = kind_t'($urandom_range(0, 4));
            rv.addr   = pool[$urandom_range(0, 4)];
            rv.data   = $urandom;
            rv.ld     = $urandom;
            rv.hit_at = $urandom_range(1, 3);
            rv.hold   = $urandom_range(0, 2);
            rv.snoop  = ($urandom_range(0, 3) == 0);
            rv.saddr  = pool[$urandom_range(0, 4)];
            model(rv);
            apply(rv, $sformatf("rand%0d", i));
        end

        // Reset asserted between edges while a load is requesting.
        mem_read_o = 1'b1; alu_out_o = 32'h500;
        @(negedge CLK);
        #1 check("pre-reset ren", {31'd0, dmemREN}, 32'd1);
        #2 RST = 1'b1;
        #1 check("async reset ren", {31'd0, dmemREN}, 32'd0);
        mem_read_o = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("post-reset stall", {31'd0, mem_stall},  32'd0);
        check("post-reset ren",   {31'd0, dmemREN},    32'd0);
        check("post-reset addr",  dmemaddr,            32'd0);
        check("post-reset rdata", mem_rdata,           32'd0);
        check("post-reset link",  {31'd0, link_valid}, 32'd0);

        halt_o = 1'b1;
        @(negedge CLK);
        halt_o = 1'b0;
        check("halt set", {31'd0, halt_flag}, 32'd1);
        repeat (3) @(negedge CLK);
        check("halt sticky", {31'd0, halt_flag}, 32'd1);
        #2 RST = 1'b1;
        #1 check("halt cleared by reset", {31'd0, halt_flag}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
